spu_arbiter: RTL

Round-robin scheduler that shares the single combinational sigmoid processing unit (spu, x_float -> y_float) between NREQ requesters, for example the software PIO bridge and hardware neuron-layer engines. It registers the operand driven into the SPU and pipelines the SPU result over SPU_LAT stages to meet timing. It then routes each result back to the requester that issued it. Each requester has at most one operation outstanding, and results are held until that requester accepts them.

---
 rtl/spu_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/spu_arbiter.sv
// spu_arbiter: round-robin sharing of one combinational sigmoid unit
// between NREQ requesters, with a registered operand and result pipeline.
module spu_arbiter #(
  parameter int NREQ    = 2,
  parameter int DATA_W  = 32,
  parameter int SPU_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_reset_n,
  input  logic                   en,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [NREQ*DATA_W-1:0] rsp_data,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      spu_x,
  input  logic [DATA_W-1:0]      spu_y,
  output logic                   busy,
  output logic [CNT_W-1:0]       op_count
);
  localparam int IW = $clog2(NREQ);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  logic [IW-1:0]          last_q;
  logic [IW-1:0]          gidx;
  logic                   gfound;
  logic [NREQ-1:0]        out_q;
  logic [NREQ-1:0]        elig;
  logic [NREQ-1:0]        hs;
  logic [DATA_W-1:0]      x_q;
  logic [NREQ-1:0]        rv_q;
  logic [NREQ*DATA_W-1:0] rd_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_inc;
  logic [SPU_LAT-1:0]     tv_q;
  logic [IW-1:0]          tid_q [SPU_LAT];
  logic [DATA_W-1:0]      fin_d;
  logic [IW-1:0]          fin_id;
  logic                   fin_v;

  assign elig = req_valid & ~out_q & {NREQ{en & reset_reset_n}};
  assign hs   = rv_q & rsp_ready;

  always_comb begin
    int j;
    j      = 0;
    gfound = 1'b0;
    gidx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last_q) + k) % NREQ;
      if (!gfound && elig[j]) begin
        gfound = 1'b1;
        gidx   = IW'(j);
      end
    end
  end

  always_comb begin
    req_ready       = '0;
    req_ready[gidx] = gfound;
  end

  always_comb begin
    cnt_inc = '0;
    for (int i = 0; i < NREQ; i++)
      cnt_inc = cnt_inc + CNT_W'(hs[i]);
  end

  assign fin_v  = tv_q[SPU_LAT-1];
  assign fin_id = tid_q[SPU_LAT-1];

  // Result data needs no reset: the token valids alone qualify it.
  if (SPU_LAT == 1) begin : g_nopipe
    assign fin_d = spu_y;
  end else begin : g_pipe
    logic [DATA_W-1:0] d_q [SPU_LAT-1];
    always_ff @(posedge CLOCK_50) begin
      d_q[0] <= spu_y;
      for (int k = 1; k < SPU_LAT - 1; k++)
        d_q[k] <= d_q[k-1];
    end
    assign fin_d = d_q[SPU_LAT-2];
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_reset_n) begin
      last_q <= LAST_RST;
      out_q  <= '0;
      x_q    <= '0;
      rv_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      tv_q   <= '0;
      for (int k = 0; k < SPU_LAT; k++)
        tid_q[k] <= '0;
    end else begin
      tv_q[0]  <= gfound;
      tid_q[0] <= gidx;
      for (int k = 1; k < SPU_LAT; k++) begin
        tv_q[k]  <= tv_q[k-1];
        tid_q[k] <= tid_q[k-1];
      end
      if (gfound) begin
        x_q    <= req_data[int'(gidx)*DATA_W +: DATA_W];
        last_q <= gidx;
      end
      out_q <= (out_q & ~hs) | req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (fin_v && fin_id == IW'(i)) begin
          rv_q[i]                    <= 1'b1;
          rd_q[i*DATA_W +: DATA_W]   <= fin_d;
        end else if (hs[i]) begin
          rv_q[i] <= 1'b0;
        end
      end
      cnt_q <= cnt_q + cnt_inc;
    end
  end

  assign spu_x     = x_q;
  assign rsp_valid = rv_q;
  assign rsp_data  = rd_q;
  assign busy      = |out_q;
  assign op_count  = cnt_q;

endmodule
